// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage.
// Contents: op encodings, forwarding select codes, FSM state type, field widths.
package ex_stage_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned FWD_W = 2;

   // Op codes 9..15 are unassigned and produce a zero result.
   typedef enum logic [OP_W-1:0] {
      OP_OR  = 4'd0,
      OP_AND = 4'd1,
      OP_XOR = 4'd2,
      OP_ADD = 4'd3,
      OP_SUB = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_SLT = 4'd7,
      OP_MUL = 4'd8
   } op_e;

   localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
   localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle between ID/EX (master) and the execute stage (slave).
// Master drives: in_valid, op, rs1_data, rs2_data, imm, alu_src, mem_write,
//                fwd_a, fwd_b, exmem_result, memwb_result.
// Slave drives:  in_ready, out_valid, result, store_data, store_en.
interface ex_stage_if #(
   parameter int unsigned W = 32
);
   import ex_stage_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  op;
   logic [W-1:0]     rs1_data;
   logic [W-1:0]     rs2_data;
   logic [W-1:0]     imm;
   logic             alu_src;
   logic             mem_write;
   logic [FWD_W-1:0] fwd_a;
   logic [FWD_W-1:0] fwd_b;
   logic [W-1:0]     exmem_result;
   logic [W-1:0]     memwb_result;
   logic             out_valid;
   logic [W-1:0]     result;
   logic [W-1:0]     store_data;
   logic             store_en;

   modport master (
      output in_valid, op, rs1_data, rs2_data, imm, alu_src, mem_write,
             fwd_a, fwd_b, exmem_result, memwb_result,
      input  in_ready, out_valid, result, store_data, store_en
   );

   modport slave (
      input  in_valid, op, rs1_data, rs2_data, imm, alu_src, mem_write,
             fwd_a, fwd_b, exmem_result, memwb_result,
      output in_ready, out_valid, result, store_data, store_en
   );

endinterface

// File: rtl/ex_stage_unit_mul.sv
// Iterative radix-2 shift-add multiplier, low W bits of the unsigned product.
// Ports: clk, reset (sync, active-high), i_start (load a/b), i_a, i_b,
//        o_busy (iteration in progress), o_done (final iteration this cycle),
//        o_product (valid while o_done is high).
// The start edge already folds in multiplier bit 0, so bits 1..W-1 take
// W-1 further edges; o_done/o_product are combinational so the owner can
// register the result on the same edge as the last iteration.
module mul_iter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_start,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_product
);
   localparam int unsigned CW = $clog2(W);

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_mcand;
   logic [W-1:0]  r_mplier;
   logic [W-1:0]  w_sum;

   // Accumulate the shifted multiplicand when the current multiplier bit is set.
   assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Counter and shift/accumulate registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= CW'(1);
         r_acc    <= i_b[0] ? i_a : '0;
         r_mcand  <= i_a << 1;
         r_mplier <= i_b >> 1;
      end else if (r_busy) begin
         r_acc    <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (r_cnt == CW'(W-1)) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_busy && (r_cnt == CW'(W-1));
   assign o_product = w_sum;

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, 8-op ALU, iterative MUL, registered outputs.
// Ports: clk, reset (sync, active-high), bus (ex_stage_if.slave).
// ALU ops complete one cycle after accept; MUL completes W cycles after
// accept with in_ready low until the result pulse.
module ex_stage_unit #(
   parameter int unsigned W      = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   ex_stage_if.slave bus
);
   import ex_stage_pkg::*;

   localparam int unsigned SHW = $clog2(W);

   state_e       r_state;
   state_e       w_next_state;
   logic         w_in_ready;
   logic         w_alu_load;
   logic         w_mul_start;
   logic         w_mul_finish;
   logic         w_is_mul;

   logic [W-1:0] w_a;
   logic [W-1:0] w_fb;
   logic [W-1:0] w_b;
   logic [W-1:0] w_alu;

   logic         w_mul_busy;
   logic         w_mul_done;
   logic [W-1:0] w_mul_product;

   logic [W-1:0] r_result;
   logic [W-1:0] r_store_data;
   logic         r_store_en;
   logic         r_out_valid;
   logic [W-1:0] r_pend_sd;
   logic         r_pend_se;

   // Forwarding muxes; code 11 falls back to the register value.
   always_comb begin
      case (bus.fwd_a)
         FWD_EXMEM: w_a = bus.exmem_result;
         FWD_MEMWB: w_a = bus.memwb_result;
         default:   w_a = bus.rs1_data;
      endcase
      case (bus.fwd_b)
         FWD_EXMEM: w_fb = bus.exmem_result;
         FWD_MEMWB: w_fb = bus.memwb_result;
         default:   w_fb = bus.rs2_data;
      endcase
   end

   // Store data always takes the forwarded rs2 value, never the immediate.
   assign w_b = bus.alu_src ? bus.imm : w_fb;

   // Single-cycle ALU; MUL lands here only when the multiplier is absent.
   always_comb begin
      w_alu = '0;
      case (bus.op)
         OP_OR:   w_alu = w_a | w_b;
         OP_AND:  w_alu = w_a & w_b;
         OP_XOR:  w_alu = w_a ^ w_b;
         OP_ADD:  w_alu = w_a + w_b;
         OP_SUB:  w_alu = w_a - w_b;
         OP_SLL:  w_alu = w_a << w_b[SHW-1:0];
         OP_SRL:  w_alu = w_a >> w_b[SHW-1:0];
         OP_SLT:  w_alu = W'($signed(w_a) < $signed(w_b));
         default: w_alu = '0;
      endcase
   end

   assign w_is_mul = MUL_EN && (bus.op == OP_MUL);

   mul_iter #(.W(W)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_a       (w_a),
      .i_b       (w_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state and control strobes; in_ready depends on state only.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_alu_load   = 1'b0;
      w_mul_start  = 1'b0;
      w_mul_finish = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               if (w_is_mul) begin
                  w_mul_start  = 1'b1;
                  w_next_state = ST_MUL;
               end else begin
                  w_alu_load = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (w_mul_done) begin
               w_mul_finish = 1'b1;
               w_next_state = ST_IDLE;
            end else if (!w_mul_busy) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Output registers; store fields for a MUL are parked until its result pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result     <= '0;
         r_store_data <= '0;
         r_store_en   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_pend_sd    <= '0;
         r_pend_se    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_alu_load) begin
            r_result     <= w_alu;
            r_store_data <= w_fb;
            r_store_en   <= bus.mem_write;
            r_out_valid  <= 1'b1;
         end
         if (w_mul_start) begin
            r_pend_sd <= w_fb;
            r_pend_se <= bus.mem_write;
         end
         if (w_mul_finish) begin
            r_result     <= w_mul_product;
            r_store_data <= r_pend_sd;
            r_store_en   <= r_pend_se;
            r_out_valid  <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.result     = r_result;
   assign bus.store_data = r_store_data;
   assign bus.store_en   = r_store_en;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_ex_stage_unit;
   localparam int unsigned W      = 32;
   localparam bit          MUL_EN = 1'b1;

   logic clk;
   logic reset;

   ex_stage_if #(.W(W)) bus ();

   ex_stage_unit #(.W(W), .MUL_EN(MUL_EN)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, expected %h", nm, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int           edge_n = 0;
   logic         m_on   = 1'b0;
   logic         m_busy;
   int           m_due;
   logic         m_valid;
   logic [W-1:0] m_result, m_sd, m_pres, m_psd;
   logic         m_se, m_pse;

   function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] r,
                                         input logic [W-1:0] ex, input logic [W-1:0] wb);
      if (sel == 2'b01) return ex;
      if (sel == 2'b10) return wb;
      return r;
   endfunction

   function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sh;
      sh = int'(b % W);
      case (op)
         0: return a | b;
         1: return a & b;
         2: return a ^ b;
         3: return a + b;
         4: return a - b;
         5: return a << sh;
         6: return a >> sh;
         7: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [W-1:0] a, b, fb;
      edge_n++;
      if (reset) begin
         m_on     = 1'b1;
         m_busy   = 1'b0;
         m_valid  = 1'b0;
         m_result = '0;
         m_sd     = '0;
         m_se     = 1'b0;
      end else if (m_on) begin
         m_valid = 1'b0;
         if (m_busy) begin
            if (edge_n == m_due) begin
               m_valid  = 1'b1;
               m_result = m_pres;
               m_sd     = m_psd;
               m_se     = m_pse;
               m_busy   = 1'b0;
            end
         end else if (bus.in_valid) begin
            a  = pick(bus.fwd_a, bus.rs1_data, bus.exmem_result, bus.memwb_result);
            fb = pick(bus.fwd_b, bus.rs2_data, bus.exmem_result, bus.memwb_result);
            b  = bus.alu_src ? bus.imm : fb;
            if (MUL_EN && bus.op == 4'd8) begin
               m_busy = 1'b1;
               m_due  = edge_n + W - 1;
               m_pres = a * b;
               m_psd  = fb;
               m_pse  = bus.mem_write;
            end else begin
               m_valid  = 1'b1;
               m_result = ref_alu(int'(bus.op), a, b);
               m_sd     = fb;
               m_se     = bus.mem_write;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_on) begin
         chk("in_ready",   W'(bus.in_ready),  W'(!m_busy));
         chk("out_valid",  W'(bus.out_valid), W'(m_valid));
         chk("result",     bus.result,        m_result);
         chk("store_data", bus.store_data,    m_sd);
         chk("store_en",   W'(bus.store_en),  W'(m_se));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [3:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                        input logic [W-1:0] im, input logic as, input logic mw,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [W-1:0] ex, input logic [W-1:0] wb);
      bus.in_valid     = 1'b1;
      bus.op           = op;
      bus.rs1_data     = r1;
      bus.rs2_data     = r2;
      bus.imm          = im;
      bus.alu_src      = as;
      bus.mem_write    = mw;
      bus.fwd_a        = fa;
      bus.fwd_b        = fb;
      bus.exmem_result = ex;
      bus.memwb_result = wb;
   endtask

   // Present one op for one edge, then drop in_valid.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                        input logic [W-1:0] im, input logic as, input logic mw,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [W-1:0] ex, input logic [W-1:0] wb);
      drive(op, r1, r2, im, as, mw, fa, fb, ex, wb);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int  n;
      bit  seen;
      reset = 1'b1;
      drive(4'd3, 32'h1, 32'h2, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);

      // Reset held with a valid ADD presented.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", W'(bus.out_valid), '0);
      chk("rst_result",    bus.result,        '0);
      chk("rst_store_en",  W'(bus.store_en),  '0);
      @(posedge clk);
      #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rdy_after_reset", W'(bus.in_ready), W'(1));

      // Forwarded ADD from EX/MEM.
      issue(4'd3, 32'h0, 32'h5, '0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h10, 32'h0);
      @(negedge clk);
      chk("add_exmem_valid", W'(bus.out_valid), W'(1));
      chk("add_exmem",       bus.result,        32'h15);

      // MEM/WB forward on B with wraparound.
      issue(4'd3, 32'h1, 32'h0, '0, 1'b0, 1'b0, 2'b00, 2'b10, 32'h0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("add_wrap", bus.result, 32'h0);

      issue(4'd7, 32'hFFFF_FFFE, 32'h1, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      @(negedge clk);
      chk("slt_signed", bus.result, 32'h1);

      issue(4'd6, 32'h8000_0000, 32'h21, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      @(negedge clk);
      chk("srl_amt_mask", bus.result, 32'h4000_0000);

      issue(4'd12, 32'hDEAD_BEEF, 32'h1234, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      @(negedge clk);
      chk("undef_op_valid", W'(bus.out_valid), W'(1));
      chk("undef_op",       bus.result,        32'h0);

      // Store: B from immediate, store data from forwarded rs2.
      issue(4'd3, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1, 2'b00, 2'b01, 32'hAB, 32'h0);
      @(negedge clk);
      chk("store_result", bus.result,        32'h108);
      chk("store_data",   bus.store_data,    32'hAB);
      chk("store_en",     W'(bus.store_en),  W'(1));
      @(posedge clk);
      #1;

      // MUL with next op held valid during the stall.
      issue(4'd8, 32'h1234, 32'h10, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      drive(4'd3, 32'h7, 32'h1, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (bus.out_valid) seen = 1'b1;
         else chk("mul_stall_ready", W'(bus.in_ready), '0);
      end
      chk("mul_latency",       W'(n),             W'(W));
      chk("mul_result",        bus.result,        32'h12340);
      chk("mul_ready_on_pulse", W'(bus.in_ready), W'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_mul_valid", W'(bus.out_valid), W'(1));
      chk("post_mul_add",   bus.result,        32'h8);

      // Reset 10 cycles into a MUL aborts it.
      issue(4'd8, 32'h55, 32'h3, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_result", bus.result,        '0);
      chk("abort_ready",  W'(bus.in_ready),  W'(1));
      chk("abort_valid",  W'(bus.out_valid), '0);
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         chk("abort_no_pulse", W'(bus.out_valid), '0);
      end
      @(posedge clk);
      #1;
      issue(4'd3, 32'h3, 32'h4, '0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
      @(negedge clk);
      chk("after_abort_valid", W'(bus.out_valid), W'(1));
      chk("after_abort_add",   bus.result,        32'h7);

      // Randomized traffic, including forwarding churn during MUL and sporadic resets.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         reset            = ($urandom_range(0, 199) == 0);
         bus.in_valid     = ($urandom_range(0, 2) != 0);
         bus.op           = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         bus.rs1_data     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 70)) : W'($urandom);
         bus.rs2_data     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 70)) : W'($urandom);
         bus.imm          = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
         bus.alu_src      = 1'($urandom_range(0, 1));
         bus.mem_write    = 1'($urandom_range(0, 1));
         bus.fwd_a        = 2'($urandom_range(0, 3));
         bus.fwd_b        = 2'($urandom_range(0, 3));
         bus.exmem_result = W'($urandom);
         bus.memwb_result = W'($urandom);
      end
      @(posedge clk);
      #1;
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
